mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported backing memory between the core's instruction-fetch port (imem_*) and data port (dmem_*). Sits between riscv_32i and the unified memory model/controller.
- Serialises requests, holds the core in stall through *_wait until its access completes, and returns read data through registered response buffers.
- Data port has fixed priority because it belongs to the older instruction. A starvation counter guarantees fetch progress.

Parameters:
- STARVE_LIMIT, 4: consecutive dmem grants made while imem_req is pending, after which imem wins the next arbitration.
- CNT_W, 3: width of the starvation counter. Must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  in  1  fetch request.
- imem_pc_addr  in  32  fetch address.
- imem_instn  out  32  fetched instruction.
- imem_wait  out  1  fetch stall to core.
- dmem_req  in  1  data request.
- dmem_we  in  1  1 = store, 0 = load.
- dmem_addr  in  32  data address.
- dmem_wd  in  32  store data.
- dmem_mask  in  4  byte enables.
- dmem_rd  out  32  load data.
- dmem_wait  out  1  data stall to core.
- mem_req  out  1  backing-memory request. Held until mem_ack.
- mem_we  out  1  backing-memory write enable.
- mem_addr  out  32  backing-memory address.
- mem_wd  out  32  backing-memory write data.
- mem_mask  out  4  backing-memory byte enables.
- mem_rd  in  32  backing-memory read data. Valid when mem_ack = 1.
- mem_ack  in  1  one-cycle completion pulse from backing memory.

Behaviour:
- States: IDLE, I_BUSY, D_BUSY, I_DONE, D_DONE.
- Reset, asynchronous, while reset = 0:
  - state = IDLE.
  - mem_req, mem_we, mem_addr, mem_wd, mem_mask = 0.
  - imem_instn, dmem_rd = 0.
  - Starvation counter = 0.
  - mem_req drops immediately even mid-transaction. Any in-flight access is abandoned and the backing memory must tolerate this.
- Wait outputs (combinational, in every state):
  - imem_wait = imem_req & !(state == I_DONE & imem_pc_addr == latched addr).
  - dmem_wait = dmem_req & !(state == D_DONE & dmem_addr, dmem_we, dmem_wd and dmem_mask all match the latched copies).
  - A port with req = 0 never sees wait = 1.
- IDLE, arbitration:
  - If dmem_req & !(imem_req & cnt >= STARVE_LIMIT): grant dmem. Go to D_BUSY.
  - Else if imem_req: grant imem. Go to I_BUSY.
  - Else stay in IDLE.
  - On grant, latch the port's addr/we/wd/mask into mem_* registers and set mem_req = 1 on the next cycle. Fetch grants set mem_we = 0 and mem_mask = 4'hF.
- Starvation counter:
  - Increments on a dmem grant while imem_req = 1. Saturates at STARVE_LIMIT.
  - Clears on any imem grant.
- I_BUSY / D_BUSY:
  - mem_req held at 1 with stable mem_* until the cycle mem_ack = 1.
  - On mem_ack, mem_rd is captured into imem_instn or dmem_rd, mem_req deasserts next cycle, and the state moves to I_DONE or D_DONE.
  - For stores, dmem_rd is still loaded from mem_rd and its value is don't-care.
- I_DONE / D_DONE:
  - Lasts exactly one cycle. Wait is low per the match rule, so the core consumes the buffered data at this clock edge. Next state is IDLE.
  - Response buffers hold their value until the next capture.
- Minimum latency with mem_ack on the first cycle of mem_req:
  - Request seen in IDLE at cycle 0, mem_req at cycle 1, ack at cycle 1, DONE at cycle 2 with wait = 0.
  - Total 3 cycles per access. Back-to-back accesses issue every 3 cycles.
- Request withdrawn mid-transaction (req drops, e.g. pipeline flush): the memory access still completes. The DONE cycle occurs and the result is discarded.
- Address or attributes changed mid-transaction (e.g. redirected fetch): the DONE match fails, wait stays high, and the arbiter returns to IDLE and re-arbitrates with the new request.
- Simultaneous imem and dmem requests every cycle:
  - Pattern is STARVE_LIMIT dmem accesses, then 1 imem access, repeating.
  - Neither port waits forever while the other keeps requesting.
- mem_ack while in IDLE or DONE is ignored.

Test Plan:
- Single fetch: imem_req = 1 with addr 0x100, memory acks on the first mem_req cycle returning 0x00500093 → mem_req = 1 with mem_addr = 0x100, mem_we = 0, mem_mask = F at cycle 1; imem_wait = 0 and imem_instn = 0x00500093 at cycle 2; mem_req = 0 at cycle 2.
- Priority: imem_req and dmem_req asserted together, dmem being a store to 0x2000 with wd 0xDEADBEEF and mask 4'b0011 → dmem served first with mem_we = 1, mem_mask = 3, mem_wd = 0xDEADBEEF; imem_wait stays 1 until its own DONE cycle at cycle 5.
- Starvation, STARVE_LIMIT = 4, both ports requesting continuously → grant sequence D,D,D,D,I,D,D,D,D,I; counter observed reaching 4 and clearing to 0.
- Variable latency: mem_ack delayed 5 cycles → mem_req and mem_addr stable for 5 cycles; imem_wait = 0 only on the cycle after the ack.
- Redirect: imem_pc_addr changes from 0x100 to 0x200 while in I_BUSY → first access completes but imem_wait stays 1; a second mem_req issues with addr 0x200 and only that result releases imem_wait.
- Reset mid-transaction: drive reset low during D_BUSY → mem_req = 0 without waiting for a clock edge; all outputs at reset values; after reset is released, a pending request is re-arbitrated from IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the core's fetch and data ports onto one single-ported backing memory.
// Data has fixed priority; a saturating starvation counter guarantees fetch progress.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        imem_req,
    input  logic [31:0] imem_pc_addr,
    output logic [31:0] imem_instn,
    output logic        imem_wait,
    input  logic        dmem_req,
    input  logic        dmem_we,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wd,
    input  logic [3:0]  dmem_mask,
    output logic [31:0] dmem_rd,
    output logic        dmem_wait,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic [3:0]  mem_mask,
    input  logic [31:0] mem_rd,
    input  logic        mem_ack
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] I_BUSY = 3'd1;
    localparam logic [2:0] D_BUSY = 3'd2;
    localparam logic [2:0] I_DONE = 3'd3;
    localparam logic [2:0] D_DONE = 3'd4;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [2:0]       state;
    logic [CNT_W-1:0] starveCnt;
    logic             starved;
    logic             grantD;
    logic             grantI;

    assign starved = imem_req && (starveCnt >= LIMIT);
    assign grantD  = (state == IDLE) && dmem_req && !starved;
    assign grantI  = (state == IDLE) && !grantD && imem_req;

    // The mem_* registers double as the latched request copy; a port is released
    // only if its current request still matches what was actually serviced.
    assign imem_wait = imem_req && !((state == I_DONE) && (imem_pc_addr == mem_addr));
    assign dmem_wait = dmem_req && !((state == D_DONE) && (dmem_addr == mem_addr) &&
                                     (dmem_we == mem_we) && (dmem_wd == mem_wd) &&
                                     (dmem_mask == mem_mask));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            starveCnt  <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wd     <= '0;
            mem_mask   <= '0;
            imem_instn <= '0;
            dmem_rd    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grantD) begin
                        state    <= D_BUSY;
                        mem_req  <= 1'b1;
                        mem_we   <= dmem_we;
                        mem_addr <= dmem_addr;
                        mem_wd   <= dmem_wd;
                        mem_mask <= dmem_mask;
                        if (imem_req && (starveCnt < LIMIT))
                            starveCnt <= starveCnt + CNT_W'(1);
                    end else if (grantI) begin
                        state     <= I_BUSY;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= imem_pc_addr;
                        mem_wd    <= '0;
                        mem_mask  <= 4'hF;
                        starveCnt <= '0;
                    end
                end
                I_BUSY: begin
                    if (mem_ack) begin
                        imem_instn <= mem_rd;
                        mem_req    <= 1'b0;
                        state      <= I_DONE;
                    end
                end
                D_BUSY: begin
                    // Stores also load dmem_rd; the core ignores it for stores.
                    if (mem_ack) begin
                        dmem_rd <= mem_rd;
                        mem_req <= 1'b0;
                        state   <= D_DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural backing memory of programmable ack delay.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req = 1'b0;
    logic [31:0] imem_pc_addr = '0;
    logic [31:0] imem_instn;
    logic        imem_wait;
    logic        dmem_req = 1'b0;
    logic        dmem_we = 1'b0;
    logic [31:0] dmem_addr = '0;
    logic [31:0] dmem_wd = '0;
    logic [3:0]  dmem_mask = '0;
    logic [31:0] dmem_rd;
    logic        dmem_wait;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [3:0]  mem_mask;
    logic [31:0] mem_rd = '0;
    logic        mem_ack = 1'b0;

    int nVec = 0;
    int nBad = 0;
    int ackDelay = 0;
    int waitCnt = 0;

    mem_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_pc_addr(imem_pc_addr), .imem_instn(imem_instn), .imem_wait(imem_wait),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wd(dmem_wd),
        .dmem_mask(dmem_mask), .dmem_rd(dmem_rd), .dmem_wait(dmem_wait),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_mask(mem_mask), .mem_rd(mem_rd), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memVal(input logic [31:0] a);
        return (a == 32'h100) ? 32'h0050_0093 : (a ^ 32'h5A5A_0000);
    endfunction

    // Memory acks on the (ackDelay+1)-th cycle of mem_req, mid-cycle.
    always @(negedge clk) begin
        if (mem_req && !mem_ack) begin
            if (waitCnt == ackDelay) begin
                mem_ack = 1'b1;
                mem_rd  = memVal(mem_addr);
                waitCnt = 0;
            end else begin
                waitCnt = waitCnt + 1;
            end
        end else begin
            mem_ack = 1'b0;
            waitCnt = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nBad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        step(); step();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_mask", 32'(mem_mask), 32'd0);
        chk("rst_instn", imem_instn, 32'd0);
        chk("rst_cnt", 32'(dut.starveCnt), 32'd0);
        reset = 1'b1;
        step();

        // Single fetch, zero-wait memory
        imem_req = 1'b1; imem_pc_addr = 32'h100;
        step();
        chk("f_mem_req", 32'(mem_req), 32'd1);
        chk("f_mem_addr", mem_addr, 32'h100);
        chk("f_mem_we", 32'(mem_we), 32'd0);
        chk("f_mem_mask", 32'(mem_mask), 32'hF);
        chk("f_wait_busy", 32'(imem_wait), 32'd1);
        step();
        chk("f_wait_done", 32'(imem_wait), 32'd0);
        chk("f_instn", imem_instn, 32'h0050_0093);
        chk("f_mem_req_done", 32'(mem_req), 32'd0);
        imem_req = 1'b0;
        step();

        // Priority: store beats fetch
        dmem_req = 1'b1; dmem_we = 1'b1; dmem_addr = 32'h2000; dmem_wd = 32'hDEAD_BEEF; dmem_mask = 4'b0011;
        imem_req = 1'b1; imem_pc_addr = 32'h300;
        step();
        chk("p_mem_we", 32'(mem_we), 32'd1);
        chk("p_mem_mask", 32'(mem_mask), 32'h3);
        chk("p_mem_wd", mem_wd, 32'hDEAD_BEEF);
        chk("p_mem_addr", mem_addr, 32'h2000);
        chk("p_cnt1", 32'(dut.starveCnt), 32'd1);
        chk("p_iwait1", 32'(imem_wait), 32'd1);
        step();
        chk("p_dwait_done", 32'(dmem_wait), 32'd0);
        chk("p_iwait2", 32'(imem_wait), 32'd1);
        dmem_req = 1'b0;
        step();
        chk("p_iwait3", 32'(imem_wait), 32'd1);
        step();
        chk("p_i_addr", mem_addr, 32'h300);
        chk("p_i_mask", 32'(mem_mask), 32'hF);
        chk("p_iwait4", 32'(imem_wait), 32'd1);
        chk("p_cnt0", 32'(dut.starveCnt), 32'd0);
        step();
        chk("p_iwait5", 32'(imem_wait), 32'd0);
        chk("p_instn", imem_instn, 32'h5A5A_0300);
        imem_req = 1'b0;
        step();

        // Starvation: both ports request continuously
        dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 32'h40; dmem_wd = 32'h0; dmem_mask = 4'hF;
        imem_req = 1'b1; imem_pc_addr = 32'h400;
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("s_grant%0d", k), mem_addr, (k % 5 == 4) ? 32'h400 : 32'h40);
            chk($sformatf("s_cnt%0d", k), 32'(dut.starveCnt), (k % 5 == 4) ? 32'd0 : 32'(k % 5 + 1));
            step();
            if (k % 5 == 4) chk($sformatf("s_iwait%0d", k), 32'(imem_wait), 32'd0);
            else            chk($sformatf("s_dwait%0d", k), 32'(dmem_wait), 32'd0);
            step();
        end
        imem_req = 1'b0; dmem_req = 1'b0;
        step();

        // Variable latency: five cycles of mem_req
        ackDelay = 4;
        imem_req = 1'b1; imem_pc_addr = 32'h500;
        step();
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("v_req%0d", j), 32'(mem_req), 32'd1);
            chk($sformatf("v_addr%0d", j), mem_addr, 32'h500);
            chk($sformatf("v_wait%0d", j), 32'(imem_wait), 32'd1);
            step();
        end
        chk("v_wait_done", 32'(imem_wait), 32'd0);
        chk("v_instn", imem_instn, 32'h5A5A_0500);
        chk("v_req_done", 32'(mem_req), 32'd0);
        imem_req = 1'b0;
        step();

        // Redirect during I_BUSY
        ackDelay = 2;
        imem_req = 1'b1; imem_pc_addr = 32'h100;
        step();
        chk("r_addr1", mem_addr, 32'h100);
        imem_pc_addr = 32'h200;
        step(); step(); step();
        chk("r_wait_stale", 32'(imem_wait), 32'd1);
        chk("r_instn_stale", imem_instn, 32'h0050_0093);
        step();
        chk("r_wait_idle", 32'(imem_wait), 32'd1);
        chk("r_req_idle", 32'(mem_req), 32'd0);
        step();
        chk("r_addr2", mem_addr, 32'h200);
        chk("r_req2", 32'(mem_req), 32'd1);
        step(); step(); step();
        chk("r_wait_done", 32'(imem_wait), 32'd0);
        chk("r_instn", imem_instn, 32'h5A5A_0200);
        imem_req = 1'b0;
        step();

        // Reset during D_BUSY
        ackDelay = 3;
        dmem_req = 1'b1; dmem_we = 1'b1; dmem_addr = 32'h3000; dmem_wd = 32'h1234_5678; dmem_mask = 4'hF;
        step();
        chk("x_req_busy", 32'(mem_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("x_req_async", 32'(mem_req), 32'd0);
        chk("x_addr", mem_addr, 32'd0);
        chk("x_wd", mem_wd, 32'd0);
        chk("x_we", 32'(mem_we), 32'd0);
        chk("x_mask", 32'(mem_mask), 32'd0);
        chk("x_instn", imem_instn, 32'd0);
        chk("x_drd", dmem_rd, 32'd0);
        chk("x_dwait", 32'(dmem_wait), 32'd1);
        step();
        ackDelay = 0;
        reset = 1'b1;
        step();
        chk("x_rearb_req", 32'(mem_req), 32'd1);
        chk("x_rearb_addr", mem_addr, 32'h3000);
        chk("x_rearb_we", 32'(mem_we), 32'd1);
        step();
        chk("x_dwait_done", 32'(dmem_wait), 32'd0);
        dmem_req = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
